// File: rtl/calc_ctrl_gen.sv
// calc_ctrl_gen: signed keypad calculator controller.
// Builds two signed decimal operands from keypad strobes, latches an operator and
// hands the operation to an external execution unit over a start/done handshake.
// Supports sign entry, clear, result chaining, entry saturation, overflow and a
// watchdog on the execution unit. Every output is driven straight from a register.
module calc_ctrl_gen #(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    nRST,
    input  logic [3:0]              digit_in,
    input  logic                    digit_valid,
    input  logic                    neg_toggle,
    input  logic [2:0]              op_in,
    input  logic                    op_valid,
    input  logic                    equal_in,
    input  logic                    clear_in,
    output logic                    exu_start,
    output logic [1:0]              exu_op,
    output logic signed [WIDTH-1:0] exu_a,
    output logic signed [WIDTH-1:0] exu_b,
    input  logic                    exu_done,
    input  logic signed [WIDTH-1:0] exu_result,
    input  logic                    exu_ovf,
    output logic signed [WIDTH-1:0] display_output,
    output logic                    complete,
    output logic                    error,
    output logic                    busy
);

    // Extended width for mag*10+digit: large enough that the product never wraps.
    localparam int EW = WIDTH + 4;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [WIDTH-1:0] MAXMAG    = {1'b0, {(WIDTH-1){1'b1}}};
    // The counter holds the number of WAIT cycles already completed, so the
    // TIMEOUT-th cycle is the one where it reads TIMEOUT-1.
    localparam logic [CW-1:0]    LAST_WAIT = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_ENTRY_A,
        S_ENTRY_B,
        S_DISPATCH,
        S_WAIT,
        S_RESULT,
        S_ERROR
    } state_t;

    // The single strobe acted on this cycle after priority resolution.
    typedef enum logic [2:0] {
        EV_NONE,
        EV_CLEAR,
        EV_EQUAL,
        EV_OP,
        EV_NEG,
        EV_DIGIT
    } event_t;

    state_t           r_state;
    state_t           w_state_next;
    event_t           w_event;

    // Operands are kept as sign + magnitude while being typed. Magnitudes are
    // WIDTH bits wide so a chained result of -2**(WIDTH-1) still fits.
    logic [WIDTH-1:0] r_mag_a;
    logic [WIDTH-1:0] r_mag_b;
    logic             r_neg_a;
    logic             r_neg_b;
    logic [1:0]       r_op;
    logic [CW-1:0]    r_wait_cnt;

    logic             r_exu_start;
    logic [1:0]       r_exu_op;
    logic [WIDTH-1:0] r_exu_a;
    logic [WIDTH-1:0] r_exu_b;
    logic [WIDTH-1:0] r_display;
    logic             r_complete;
    logic             r_error;
    logic             r_busy;

    logic             w_op_onehot;
    logic [1:0]       w_op_code;
    logic             w_digit_ok;
    logic             w_entry_b;
    logic [WIDTH-1:0] w_cur_mag;
    logic             w_cur_neg;
    logic [EW-1:0]    w_mag_ext;
    logic             w_digit_fits;
    logic [WIDTH-1:0] w_ent_mag_next;
    logic             w_ent_neg_next;
    logic             w_timeout;
    logic [WIDTH-1:0] w_result_abs;

    // Two's complement value of a sign/magnitude pair; a negative zero yields 0.
    function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] mag,
                                                    input logic             neg);
        return neg ? (~mag + WIDTH'(1)) : mag;
    endfunction

    // Resolve simultaneous strobes: clear > equal > op > neg > digit.
    always_comb begin
        // NOTE: every variable written in a combinational block gets a default
        // first, so no path leaves it unassigned and no latch is inferred.
        w_event = EV_NONE;
        if (clear_in)         w_event = EV_CLEAR;
        else if (equal_in)    w_event = EV_EQUAL;
        else if (op_valid)    w_event = EV_OP;
        else if (neg_toggle)  w_event = EV_NEG;
        else if (digit_valid) w_event = EV_DIGIT;
    end

    // Decode the one-hot keypad operator into the execution unit's encoding.
    always_comb begin
        w_op_onehot = 1'b1;
        w_op_code   = 2'd0;
        case (op_in)
            3'b001:  w_op_code = 2'd0;
            3'b010:  w_op_code = 2'd1;
            3'b100:  w_op_code = 2'd2;
            default: w_op_onehot = 1'b0;
        endcase
    end

    // The operand currently being typed and its saturating decimal shift.
    assign w_entry_b    = (r_state == S_ENTRY_B);
    assign w_cur_mag    = w_entry_b ? r_mag_b : r_mag_a;
    assign w_cur_neg    = w_entry_b ? r_neg_b : r_neg_a;
    assign w_digit_ok   = (digit_in <= 4'd9);
    assign w_mag_ext    = EW'(w_cur_mag) * EW'(10) + EW'(digit_in);
    assign w_digit_fits = (w_mag_ext <= EW'(MAXMAG));
    assign w_timeout    = (r_wait_cnt == LAST_WAIT);
    assign w_result_abs = r_display[WIDTH-1] ? (~r_display + WIDTH'(1)) : r_display;

    // Next value of the operand being typed, given this cycle's strobe.
    always_comb begin
        w_ent_mag_next = w_cur_mag;
        w_ent_neg_next = w_cur_neg;
        if (w_event == EV_DIGIT && w_digit_ok && w_digit_fits)
            w_ent_mag_next = w_mag_ext[WIDTH-1:0];
        if (w_event == EV_NEG)
            w_ent_neg_next = ~w_cur_neg;
    end

    // Next-state logic of the controller.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_ENTRY_A: begin
                if (w_event == EV_OP && w_op_onehot)
                    w_state_next = S_ENTRY_B;
            end
            S_ENTRY_B: begin
                if (w_event == EV_EQUAL)
                    w_state_next = S_DISPATCH;
            end
            S_DISPATCH: w_state_next = S_WAIT;
            S_WAIT: begin
                // A done arriving on the last allowed cycle still wins over the timeout.
                if (exu_done)
                    w_state_next = exu_ovf ? S_ERROR : S_RESULT;
                else if (w_timeout)
                    w_state_next = S_ERROR;
            end
            S_RESULT: begin
                if (w_event == EV_OP && w_op_onehot)
                    w_state_next = S_ENTRY_B;
                else if (w_event == EV_DIGIT && w_digit_ok)
                    w_state_next = S_ENTRY_A;
            end
            S_ERROR: w_state_next = S_ERROR;
            default: w_state_next = S_ENTRY_A;
        endcase
        if (w_event == EV_CLEAR)
            w_state_next = S_ENTRY_A;
    end

    // State register.
    always_ff @(posedge clk or negedge nRST) begin
        // NOTE: sequential state is assigned with <= so every register samples
        // the pre-edge values regardless of block ordering.
        if (!nRST) r_state <= S_ENTRY_A;
        else       r_state <= w_state_next;
    end

    // Operand entry, operator latch and result chaining.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_mag_a <= '0;
            r_mag_b <= '0;
            r_neg_a <= 1'b0;
            r_neg_b <= 1'b0;
            r_op    <= 2'd0;
        end else if (w_event == EV_CLEAR) begin
            r_mag_a <= '0;
            r_mag_b <= '0;
            r_neg_a <= 1'b0;
            r_neg_b <= 1'b0;
            r_op    <= 2'd0;
        end else begin
            case (r_state)
                S_ENTRY_A: begin
                    if (w_event == EV_DIGIT || w_event == EV_NEG) begin
                        r_mag_a <= w_ent_mag_next;
                        r_neg_a <= w_ent_neg_next;
                    end
                    if (w_event == EV_OP && w_op_onehot) begin
                        r_op    <= w_op_code;
                        r_mag_b <= '0;
                        r_neg_b <= 1'b0;
                    end
                end
                S_ENTRY_B: begin
                    if (w_event == EV_DIGIT || w_event == EV_NEG) begin
                        r_mag_b <= w_ent_mag_next;
                        r_neg_b <= w_ent_neg_next;
                    end
                    if (w_event == EV_OP && w_op_onehot)
                        r_op <= w_op_code;
                end
                S_RESULT: begin
                    if (w_event == EV_OP && w_op_onehot) begin
                        // Chain: the displayed result becomes operand A.
                        r_mag_a <= w_result_abs;
                        r_neg_a <= r_display[WIDTH-1];
                        r_op    <= w_op_code;
                        r_mag_b <= '0;
                        r_neg_b <= 1'b0;
                    end else if (w_event == EV_DIGIT && w_digit_ok) begin
                        // Fresh calculation started by typing a digit.
                        r_mag_a <= WIDTH'(digit_in);
                        r_neg_a <= 1'b0;
                        r_mag_b <= '0;
                        r_neg_b <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Execution-unit request: operands and op held from start until the next dispatch.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_exu_start <= 1'b0;
            r_exu_op    <= 2'd0;
            r_exu_a     <= '0;
            r_exu_b     <= '0;
        end else if (w_event == EV_CLEAR) begin
            r_exu_start <= 1'b0;
            r_exu_op    <= 2'd0;
            r_exu_a     <= '0;
            r_exu_b     <= '0;
        end else begin
            r_exu_start <= 1'b0;
            if (r_state == S_ENTRY_B && w_event == EV_EQUAL) begin
                r_exu_start <= 1'b1;
                r_exu_op    <= r_op;
                r_exu_a     <= apply_sign(r_mag_a, r_neg_a);
                r_exu_b     <= apply_sign(r_mag_b, r_neg_b);
            end
        end
    end

    // Watchdog: counts completed WAIT cycles, restarted on every dispatch.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST)
            r_wait_cnt <= '0;
        else if (w_event == EV_CLEAR || r_state == S_DISPATCH)
            r_wait_cnt <= '0;
        else if (r_state == S_WAIT)
            r_wait_cnt <= r_wait_cnt + CW'(1);
    end

    // Display and status flags.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_display  <= '0;
            r_complete <= 1'b0;
            r_error    <= 1'b0;
            r_busy     <= 1'b0;
        end else if (w_event == EV_CLEAR) begin
            r_display  <= '0;
            r_complete <= 1'b0;
            r_error    <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                S_ENTRY_A, S_ENTRY_B: begin
                    // Echo the operand being typed; a dropped digit still refreshes it.
                    if ((w_event == EV_DIGIT && w_digit_ok) || w_event == EV_NEG)
                        r_display <= apply_sign(w_ent_mag_next, w_ent_neg_next);
                    if (r_state == S_ENTRY_B && w_event == EV_EQUAL)
                        r_busy <= 1'b1;
                end
                S_WAIT: begin
                    if (exu_done) begin
                        r_busy <= 1'b0;
                        if (exu_ovf) begin
                            r_error   <= 1'b1;
                            r_display <= '0;
                        end else begin
                            r_display  <= exu_result;
                            r_complete <= 1'b1;
                        end
                    end else if (w_timeout) begin
                        r_busy    <= 1'b0;
                        r_error   <= 1'b1;
                        r_display <= '0;
                    end
                end
                S_RESULT: begin
                    if (w_event == EV_OP && w_op_onehot) begin
                        r_complete <= 1'b0;
                    end else if (w_event == EV_DIGIT && w_digit_ok) begin
                        r_complete <= 1'b0;
                        r_display  <= WIDTH'(digit_in);
                    end
                end
                default: ;
            endcase
        end
    end

    assign exu_start      = r_exu_start;
    assign exu_op         = r_exu_op;
    assign exu_a          = r_exu_a;
    assign exu_b          = r_exu_b;
    assign display_output = r_display;
    assign complete       = r_complete;
    assign error          = r_error;
    assign busy           = r_busy;

endmodule

// File: tb/tb_calc_ctrl_gen.sv
// tb_calc_ctrl_gen: directed scenarios plus randomized keypad traffic, all checked
// cycle by cycle against a behavioural calculator model held in integers.
`timescale 1ns/1ps
module tb_calc_ctrl_gen;

    localparam int W      = 16;
    localparam int TO     = 64;
    localparam int MAXMAG = 32767;

    logic                clk = 1'b0;
    logic                nRST;
    logic [3:0]          digit_in;
    logic                digit_valid;
    logic                neg_toggle;
    logic [2:0]          op_in;
    logic                op_valid;
    logic                equal_in;
    logic                clear_in;
    logic                exu_start;
    logic [1:0]          exu_op;
    logic signed [W-1:0] exu_a;
    logic signed [W-1:0] exu_b;
    logic                exu_done;
    logic signed [W-1:0] exu_result;
    logic                exu_ovf;
    logic signed [W-1:0] display_output;
    logic                complete;
    logic                error;
    logic                busy;

    calc_ctrl_gen #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk           (clk),
        .nRST          (nRST),
        .digit_in      (digit_in),
        .digit_valid   (digit_valid),
        .neg_toggle    (neg_toggle),
        .op_in         (op_in),
        .op_valid      (op_valid),
        .equal_in      (equal_in),
        .clear_in      (clear_in),
        .exu_start     (exu_start),
        .exu_op        (exu_op),
        .exu_a         (exu_a),
        .exu_b         (exu_b),
        .exu_done      (exu_done),
        .exu_result    (exu_result),
        .exu_ovf       (exu_ovf),
        .display_output(display_output),
        .complete      (complete),
        .error         (error),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef enum {M_ENTER_A, M_ENTER_B, M_LAUNCH, M_PENDING, M_SHOW, M_FAULT} mode_t;
    mode_t m_mode;
    int    m_a_mag, m_b_mag, m_op, m_disp, m_ea, m_eb, m_eop, m_pend_since;
    bit    m_a_neg, m_b_neg, m_start, m_busy, m_complete, m_error;
    int    cyc = 0;

    // Execution-unit responder settings.
    int    rsp_latency = 1;
    bit    rsp_never   = 1'b0;
    bit    noise_en    = 1'b0;

    function automatic int signed_of(input int mag, input bit neg);
        return neg ? -mag : mag;
    endfunction

    task automatic model_clear();
        m_mode = M_ENTER_A;
        m_a_mag = 0; m_b_mag = 0; m_a_neg = 0; m_b_neg = 0; m_op = 0;
        m_disp = 0; m_ea = 0; m_eb = 0; m_eop = 0;
        m_start = 0; m_busy = 0; m_complete = 0; m_error = 0;
    endtask

    task automatic model_step();
        int d;
        bit onehot;
        int code;
        bit in_b;
        d      = int'(digit_in);
        onehot = (op_in == 3'b001) || (op_in == 3'b010) || (op_in == 3'b100);
        code   = (op_in == 3'b001) ? 0 : (op_in == 3'b010) ? 1 : 2;
        m_start = 0;
        if (clear_in) begin
            model_clear();
            return;
        end
        case (m_mode)
            M_ENTER_A, M_ENTER_B: begin
                in_b = (m_mode == M_ENTER_B);
                if (equal_in) begin
                    if (in_b) begin
                        m_ea = signed_of(m_a_mag, m_a_neg);
                        m_eb = signed_of(m_b_mag, m_b_neg);
                        m_eop = m_op; m_start = 1; m_busy = 1; m_mode = M_LAUNCH;
                    end
                end else if (op_valid) begin
                    if (onehot) begin
                        m_op = code;
                        if (!in_b) begin m_b_mag = 0; m_b_neg = 0; m_mode = M_ENTER_B; end
                    end
                end else if (neg_toggle) begin
                    if (in_b) begin m_b_neg = !m_b_neg; m_disp = signed_of(m_b_mag, m_b_neg); end
                    else      begin m_a_neg = !m_a_neg; m_disp = signed_of(m_a_mag, m_a_neg); end
                end else if (digit_valid && d <= 9) begin
                    if (in_b) begin
                        if (m_b_mag * 10 + d <= MAXMAG) m_b_mag = m_b_mag * 10 + d;
                        m_disp = signed_of(m_b_mag, m_b_neg);
                    end else begin
                        if (m_a_mag * 10 + d <= MAXMAG) m_a_mag = m_a_mag * 10 + d;
                        m_disp = signed_of(m_a_mag, m_a_neg);
                    end
                end
            end
            M_LAUNCH: begin
                m_mode = M_PENDING;
                m_pend_since = cyc;
            end
            M_PENDING: begin
                if (exu_done) begin
                    m_busy = 0;
                    if (exu_ovf) begin m_error = 1; m_disp = 0; m_mode = M_FAULT; end
                    else begin m_disp = int'(exu_result); m_complete = 1; m_mode = M_SHOW; end
                end else if (cyc - m_pend_since >= TO) begin
                    m_busy = 0; m_error = 1; m_disp = 0; m_mode = M_FAULT;
                end
            end
            M_SHOW: begin
                if (equal_in) begin
                end else if (op_valid) begin
                    if (onehot) begin
                        m_a_mag = (m_disp < 0) ? -m_disp : m_disp;
                        m_a_neg = (m_disp < 0);
                        m_op = code; m_b_mag = 0; m_b_neg = 0;
                        m_complete = 0; m_mode = M_ENTER_B;
                    end
                end else if (neg_toggle) begin
                end else if (digit_valid && d <= 9) begin
                    m_a_mag = d; m_a_neg = 0; m_b_mag = 0; m_b_neg = 0;
                    m_disp = d; m_complete = 0; m_mode = M_ENTER_A;
                end
            end
            default: ;
        endcase
    endtask

    task automatic compare();
        check("display",  display_output, W'(m_disp));
        check("complete", complete,       W'(m_complete));
        check("error",    error,          W'(m_error));
        check("busy",     busy,           W'(m_busy));
        check("exu_start", exu_start,     W'(m_start));
        check("exu_a",    exu_a,          W'(m_ea));
        check("exu_b",    exu_b,          W'(m_eb));
        check("exu_op",   exu_op,         W'(m_eop));
    endtask

    // Acts as the execution unit: answers with the true arithmetic result.
    task automatic respond();
        int t;
        if (m_mode == M_PENDING) begin
            if (!rsp_never && (cyc + 1 - m_pend_since) == rsp_latency) begin
                case (m_eop)
                    0:       t = m_ea + m_eb;
                    1:       t = m_ea - m_eb;
                    default: t = m_ea * m_eb;
                endcase
                exu_done   = 1'b1;
                exu_result = W'(t);
                exu_ovf    = (t > MAXMAG) || (t < -MAXMAG - 1);
            end else begin
                exu_done = 1'b0;
            end
        end else if (noise_en) begin
            exu_done   = ($urandom_range(0, 15) == 0);
            exu_result = W'($urandom);
            exu_ovf    = 1'($urandom_range(0, 1));
        end
    endtask

    // One clock: stimulus already applied, advance DUT and model, compare, release strobes.
    task automatic tick();
        respond();
        @(posedge clk);
        cyc++;
        model_step();
        #1;
        compare();
        @(negedge clk);
        digit_valid = 0; neg_toggle = 0; op_valid = 0; equal_in = 0; clear_in = 0;
        exu_done = 0;
    endtask

    task automatic press_digit(input int d);
        digit_in = 4'(d); digit_valid = 1; tick();
    endtask
    task automatic press_op(input logic [2:0] o);
        op_in = o; op_valid = 1; tick();
    endtask
    task automatic press_neg();
        neg_toggle = 1; tick();
    endtask
    task automatic press_equal();
        equal_in = 1; tick();
    endtask
    task automatic press_clear();
        clear_in = 1; tick();
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        nRST = 0; digit_in = 0; digit_valid = 0; neg_toggle = 0; op_in = 0;
        op_valid = 0; equal_in = 0; clear_in = 0; exu_done = 0; exu_result = 0; exu_ovf = 0;
        model_clear();
        repeat (3) @(negedge clk);
        compare();
        nRST = 1;

        // 1: 12 + 34 with a 3-cycle execution unit
        rsp_latency = 3;
        press_digit(1); press_digit(2);
        check("t1_disp_a", display_output, 16'd12);
        press_op(3'b001); press_digit(3); press_digit(4);
        check("t1_disp_b", display_output, 16'd34);
        press_equal();
        check("t1_start", exu_start, 16'd1);
        check("t1_busy", busy, 16'd1);
        idle(1);
        check("t1_start_drop", exu_start, 16'd0);
        idle(3);
        check("t1_result", display_output, 16'd46);
        check("t1_complete", complete, 16'd1);

        // 6: chain 46 + 4
        rsp_latency = 1;
        press_op(3'b001);
        check("t6_complete_drop", complete, 16'd0);
        press_digit(4); press_equal();
        check("t6_exu_a", exu_a, 16'd46);
        check("t6_exu_b", exu_b, 16'd4);
        idle(2);
        check("t6_result", display_output, 16'd50);

        // 2: 7 - 20 = -13, started by a digit in RESULT
        rsp_latency = 2;
        press_digit(7);
        check("t2_disp_a", display_output, 16'd7);
        press_op(3'b010); press_digit(2); press_digit(0); press_equal();
        check("t2_exu_a", exu_a, 16'd7);
        check("t2_exu_b", exu_b, 16'd20);
        check("t2_exu_op", exu_op, 16'd1);
        idle(3);
        check("t2_result", display_output, 16'hFFF3);

        // 4: entry saturation and sign
        press_clear();
        for (int i = 0; i < 5; i++) press_digit(9);
        check("t4_sat", display_output, 16'd9999);
        press_neg();
        check("t4_neg", display_output, 16'hD8F1);

        // 3: -250 * 300 overflows
        press_clear(); press_neg(); press_digit(2); press_digit(5); press_digit(0);
        check("t3_disp_a", display_output, 16'hFF06);
        press_op(3'b100); press_digit(3); press_digit(0); press_digit(0); press_equal();
        idle(3);
        check("t3_error", error, 16'd1);
        check("t3_disp0", display_output, 16'd0);
        press_digit(5);
        check("t3_error_hold", error, 16'd1);
        press_clear();
        check("t3_clear_err", error, 16'd0);

        // 5: watchdog, then clear mid-WAIT
        rsp_never = 1;
        press_digit(3); press_op(3'b001); press_digit(1); press_equal();
        idle(TO);
        check("t5_before_to", error, 16'd0);
        check("t5_busy", busy, 16'd1);
        idle(1);
        check("t5_timeout", error, 16'd1);
        check("t5_busy_drop", busy, 16'd0);
        press_clear(); press_digit(3); press_op(3'b001); press_digit(1); press_equal();
        idle(5);
        press_clear();
        check("t5_clear_busy", busy, 16'd0);

        // reset mid-WAIT, then a late done must be ignored
        press_digit(2); press_op(3'b010); press_digit(2); press_equal(); idle(2);
        nRST = 0;
        #2;
        model_clear();
        compare();
        @(negedge clk);
        nRST = 1;
        exu_done = 1; exu_result = 16'd77; exu_ovf = 0;
        tick();
        check("rst_late_done", display_output, 16'd0);

        // randomized traffic
        rsp_never = 0;
        noise_en  = 1;
        for (int n = 0; n < 4000; n++) begin
            if (m_mode == M_LAUNCH) begin
                rsp_latency = $urandom_range(1, 6);
                rsp_never   = ($urandom_range(0, 9) == 0);
            end
            clear_in    = ($urandom_range(0, 99) < 2);
            equal_in    = ($urandom_range(0, 99) < 10);
            op_valid    = ($urandom_range(0, 99) < 15);
            neg_toggle  = ($urandom_range(0, 99) < 8);
            digit_valid = ($urandom_range(0, 99) < 50);
            digit_in    = 4'($urandom_range(0, 11));
            case ($urandom_range(0, 9))
                0, 1, 2: op_in = 3'b001;
                3, 4, 5: op_in = 3'b010;
                6, 7:    op_in = 3'b100;
                default: op_in = 3'($urandom);
            endcase
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
